lr_consistency_check: RTL and testbench



---
 rtl/postproc_pkg.sv | 18 +
 rtl/lr_line_ram.sv | 23 ++
 rtl/lr_consistency_check.sv | 126 ++++++++++++
 tb/tb_lr_consistency_check.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/postproc_pkg.sv
// Shared constants for the disparity post-processing chain (lr_consistency_check, hole_filling).
// Both stages take their flag positions and default codes from here so they stay in agreement.
package postproc_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned FRAC_DEF   = 4;
  localparam int unsigned THR_DEF    = 16;
  localparam logic [15:0] INVALID_DEF = 16'hFFFF;

  localparam int unsigned FLAG_MIS = DWIDTH_DEF + 1;
  localparam int unsigned FLAG_OCC = DWIDTH_DEF;

  typedef struct packed {
    logic mis;
    logic occ;
  } lr_flags_t;

endpackage

// File: rtl/lr_line_ram.sv
// Single right-disparity line buffer: one write port, one synchronous read port.
// On a same-address collision the read returns the old word.
module lr_line_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lr_consistency_check.sv
// Left-right disparity consistency check; tags each left disparity with {mismatch, occlusion}.
// Three-stage pipeline: accept/RAM access, RAM read data, classify/register output.
module lr_consistency_check
  import postproc_pkg::*;
#(
  parameter int unsigned      DWIDTH  = DWIDTH_DEF,
  parameter int unsigned      FRAC    = FRAC_DEF,
  parameter int unsigned      THR     = THR_DEF,
  parameter logic [DWIDTH-1:0] INVALID = INVALID_DEF,
  parameter int unsigned      AW      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AW-1:0]     width,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] disp_l,
  input  logic [DWIDTH-1:0] disp_r,
  output logic              valid,
  output logic [DWIDTH+1:0] dout,
  output logic              eol
);

  localparam int unsigned IW = DWIDTH - FRAC;

  logic              accept;
  logic [AW-1:0]     col_q, col_d;
  logic              last_col;
  logic [IW-1:0]     di;
  logic              oob, byp;
  logic [AW-1:0]     ra;
  logic [DWIDTH-1:0] ram_rdata;

  assign accept   = clken & in_valid;
  assign last_col = (col_q == width - AW'(1));
  assign di       = disp_l[DWIDTH-1:FRAC];
  assign oob      = (32'(di) > 32'(col_q));
  assign ra       = col_q - AW'(di);
  // di==0 reads the address being written this cycle; the RAM would return the old row.
  assign byp      = (di == '0);

  always_comb begin
    col_d = col_q;
    if (accept) col_d = last_col ? '0 : col_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) col_q <= '0;
    else     col_q <= col_d;
  end

  lr_line_ram #(
    .AW (AW),
    .DW (DWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (col_q),
    .wdata (disp_r),
    .re    (accept),
    .raddr (ra),
    .rdata (ram_rdata)
  );

  // Stage 1
  logic              s1_valid_q, s1_oob_q, s1_byp_q, s1_eol_q;
  logic [DWIDTH-1:0] s1_disp_l_q, s1_byp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_oob_q      <= 1'b0;
      s1_byp_q      <= 1'b0;
      s1_eol_q      <= 1'b0;
      s1_disp_l_q   <= '0;
      s1_byp_data_q <= '0;
    end else if (clken) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_oob_q      <= oob;
        s1_byp_q      <= byp;
        s1_eol_q      <= last_col;
        s1_disp_l_q   <= disp_l;
        s1_byp_data_q <= disp_r;
      end
    end
  end

  // Stage 2: classify
  logic [DWIDTH-1:0]        dr;
  logic signed [DWIDTH:0]   diff;
  logic [DWIDTH:0]          adiff;
  lr_flags_t                flags;

  always_comb begin
    dr    = s1_byp_q ? s1_byp_data_q : ram_rdata;
    diff  = $signed({1'b0, s1_disp_l_q}) - $signed({1'b0, dr});
    adiff = diff[DWIDTH] ? $unsigned(-diff) : $unsigned(diff);
    flags = '0;
    if (s1_disp_l_q == INVALID)       flags.mis = 1'b1;
    else if (s1_oob_q)                flags.occ = 1'b1;
    else if (adiff <= (DWIDTH+1)'(THR)) flags = '0;
    else if (dr > s1_disp_l_q)        flags.occ = 1'b1;
    else                              flags.mis = 1'b1;
  end

  logic              valid_q, eol_q;
  logic [DWIDTH+1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      dout_q  <= '0;
    end else if (clken) begin
      valid_q <= s1_valid_q;
      eol_q   <= s1_valid_q & s1_eol_q;
      if (s1_valid_q) dout_q <= {flags.mis, flags.occ, s1_disp_l_q};
    end
  end

  assign valid = valid_q;
  assign eol   = eol_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_lr_consistency_check.sv
// Directed table-driven bench for lr_consistency_check, with stall/bubble and mid-row reset runs.
module tb_lr_consistency_check;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 11;
  localparam int unsigned NV = 72;

  logic          clk = 1'b0;
  logic          rst, clken, in_valid;
  logic [AW-1:0] width;
  logic [DW-1:0] disp_l, disp_r;
  logic          valid, eol;
  logic [DW+1:0] dout;

  lr_consistency_check dut (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .width    (width),
    .in_valid (in_valid),
    .disp_l   (disp_l),
    .disp_r   (disp_r),
    .valid    (valid),
    .dout     (dout),
    .eol      (eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dl;
    logic [DW-1:0] dr;
    logic [DW+1:0] exp;
    logic          eol;
  } vec_t;

  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  int exp_idx, exp_hi, nvalid, naccept;
  bit mon_en = 1'b0;
  bit prev_clken = 1'b1;
  logic          prev_valid;
  logic [DW+1:0] prev_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic setv(input int i, input logic [DW-1:0] dl, input logic [DW-1:0] dr,
                      input logic [DW+1:0] e, input logic el);
    vecs[i].dl  = dl;
    vecs[i].dr  = dr;
    vecs[i].exp = e;
    vecs[i].eol = el;
  endtask

  // Output monitor: compares fresh outputs against the table, checks hold during stalls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!prev_clken) begin
        check("hold_valid", 32'(valid), 32'(prev_valid));
        check("hold_dout", 32'(dout), 32'(prev_dout));
      end else if (valid) begin
        nvalid++;
        if (exp_idx > exp_hi) begin
          checks++;
          errors++;
          $display("FAIL extra_valid: got dout 0x%0h, expected no output", dout);
        end else begin
          check("dout", 32'(dout), 32'(vecs[exp_idx].exp));
          check("eol", 32'(eol), 32'(vecs[exp_idx].eol));
          exp_idx++;
        end
      end
    end
    prev_clken = clken;
    prev_valid = valid;
    prev_dout  = dout;
  end

  task automatic run(input int lo, input int hi, input bit stall);
    exp_idx = lo;
    exp_hi  = hi;
    nvalid  = 0;
    naccept = 0;
    mon_en  = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      int tries;
      bit acc;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 200) begin
        disp_l = vecs[i].dl;
        disp_r = vecs[i].dr;
        if (stall) begin
          clken    = 1'($urandom_range(0, 1));
          in_valid = ($urandom_range(0, 3) != 0);
        end else begin
          clken    = 1'b1;
          in_valid = 1'b1;
        end
        acc = clken & in_valid;
        if (acc) naccept++;
        @(posedge clk);
        #1;
        tries++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: vector %0d not accepted, expected acceptance", i);
      end
    end
    clken    = 1'b1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    mon_en = 1'b0;
    check("valid_count", 32'(nvalid), 32'(naccept));
    check("outputs_seen", 32'(exp_idx), 32'(hi + 1));
  endtask

  initial begin
    logic [DW-1:0] rx[3];
    logic [DW+1:0] e2[3];
    logic [DW+1:0] e5[3];
    rx = '{16'h0040, 16'h0050, 16'h0010};
    e2 = '{18'h10000, 18'h10000, 18'h00000};
    e5 = '{18'h00030, 18'h10030, 18'h20030};

    // 0..15: 2 px disparity, left edge occluded
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++)
        setv(r*8 + c, 16'h0020, 16'h0020, (c < 2) ? 18'h10020 : 18'h00020, c == 7);
    // 16..31: zero disparity must bypass the stale row
    for (int c = 0; c < 8; c++) begin
      setv(16 + c, 16'h0000, 16'h0100, 18'h10000, c == 7);
      setv(24 + c, 16'h0000, 16'h0000, 18'h00000, c == 7);
    end
    // 32..55: col 5 dL=3 px against R[2]
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        setv(32 + r*8 + c, (c == 5) ? 16'h0030 : 16'h0000, (c == 2) ? rx[r] : 16'h0000,
             (c == 5) ? e5[r] : ((c == 2) ? e2[r] : 18'h00000), c == 7);
    // 56..63: invalid code at cols 0 and 6
    for (int c = 0; c < 8; c++)
      setv(56 + c, (c == 0 || c == 6) ? 16'hFFFF : 16'h0000, 16'h0000,
           (c == 0 || c == 6) ? 18'h2FFFF : 18'h00000, c == 7);
    // 64..71: row after mid-row reset
    for (int c = 0; c < 8; c++)
      setv(64 + c, 16'h0010, 16'h0010, (c == 0) ? 18'h10010 : 18'h00010, c == 7);

    rst      = 1'b1;
    clken    = 1'b1;
    in_valid = 1'b0;
    width    = AW'(8);
    disp_l   = '0;
    disp_r   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_eol", 32'(eol), 32'd0);

    run(0, 63, 1'b0);
    run(0, 15, 1'b1);

    // Mid-row reset after accepting cols 0..4
    clken    = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      disp_l = 16'h0010;
      disp_r = 16'h0010;
      @(posedge clk);
      #1;
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("valid_after_rst", 32'(valid), 32'd0);
    check("dout_after_rst", 32'(dout), 32'd0);
    run(64, 71, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
